tcam_prio_search: RTL

- Parametrised ternary CAM with per-entry valid bits, per-bit care masks, a 2-stage registered search pipeline and a lowest-index priority encoder.
- Successor to the flat match-vector TCAM. Adds entry invalidate and flush, a search handshake, an encoded hit index and table-occupancy tracking.
- Sits between the packet-header parser (search key source) and the action lookup table (indexed by rsp_index).

---
 rtl/tcam_prio_search.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tcam_prio_search.sv
// Ternary CAM with per-entry valid bits and care masks, a 2-stage search pipeline and a lowest-index hit encoder.
// Define TCAM_MULTI_HIT_EN to add the rsp_multi / rsp_count outputs.
module tcam_prio_search #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             srch_valid,
  input  logic [WIDTH-1:0] srch_key,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_value,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             inv_en,
  input  logic [AW-1:0]    inv_addr,
  input  logic             flush,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [AW-1:0]    rsp_index,
  output logic [DEPTH-1:0] rsp_match,
  output logic [AW:0]      occupancy
`ifdef TCAM_MULTI_HIT_EN
  ,
  output logic             rsp_multi,
  output logic [AW:0]      rsp_count
`endif
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] value_q [DEPTH];
  logic [WIDTH-1:0] care_q  [DEPTH];
  logic [AW:0]      occupancy_q;
  logic             wr_ok, inv_ok;

  logic [DEPTH-1:0] match_p0;
  logic             vld_p1_q;
  logic [DEPTH-1:0] match_p1_q;

  logic             rsp_valid_q;
  logic             rsp_hit_q;
  logic [AW-1:0]    rsp_index_q;
  logic [DEPTH-1:0] rsp_match_q;
`ifdef TCAM_MULTI_HIT_EN
  logic             rsp_multi_q;
  logic [AW:0]      rsp_count_q;
  logic [AW:0]      hit_count_p1;
`endif

  function automatic logic [AW-1:0] prio_enc(input logic [DEPTH-1:0] m);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + (AW+1)'(v[i]);
    end
    return cnt;
  endfunction

  // When DEPTH fills the address space every address is in range.
  generate
    if (DEPTH == (1 << AW)) begin : g_full_range
      assign wr_ok  = 1'b1;
      assign inv_ok = 1'b1;
    end else begin : g_part_range
      localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
      assign wr_ok  = ({1'b0, wr_addr}  < DEPTH_C);
      assign inv_ok = ({1'b0, inv_addr} < DEPTH_C);
    end
  endgenerate

  // Flush first, then invalidate, then write, so a write always wins.
  always_comb begin
    valid_d = valid_q;
    if (flush) valid_d = '0;
    if (inv_en && inv_ok) valid_d[inv_addr] = 1'b0;
    if (wr_en && wr_ok) valid_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= popcount(valid_d);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      value_q[wr_addr] <= wr_value;
      care_q[wr_addr]  <= wr_care;
    end
  end

  // Compare against the pre-update table, giving read-before-write semantics.
  always_comb begin
    match_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_p0[i] = valid_q[i] & (&(~(srch_key ^ value_q[i]) | ~care_q[i]));
    end
  end

  // ---- stage 1: registered match vector ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1_q <= 1'b0;
    else        vld_p1_q <= srch_valid;
  end

  always_ff @(posedge clk) begin
    if (srch_valid) match_p1_q <= match_p0;
  end

`ifdef TCAM_MULTI_HIT_EN
  assign hit_count_p1 = popcount(match_p1_q);
`endif

  // ---- stage 2: priority encode, results hold between requests ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_match_q <= '0;
`ifdef TCAM_MULTI_HIT_EN
      rsp_multi_q <= 1'b0;
      rsp_count_q <= '0;
`endif
    end else begin
      rsp_valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        rsp_hit_q   <= |match_p1_q;
        rsp_index_q <= prio_enc(match_p1_q);
        rsp_match_q <= match_p1_q;
`ifdef TCAM_MULTI_HIT_EN
        rsp_multi_q <= (hit_count_p1 > (AW+1)'(1));
        rsp_count_q <= hit_count_p1;
`endif
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_index = rsp_index_q;
  assign rsp_match = rsp_match_q;
  assign occupancy = occupancy_q;
`ifdef TCAM_MULTI_HIT_EN
  assign rsp_multi = rsp_multi_q;
  assign rsp_count = rsp_count_q;
`endif

endmodule
